// File: rtl/eproc_out_enc8b10b.sv
`timescale 1ns/1ps
// E-link egress: fetches one FIFO word per 5-cycle frame, 8b/10b-encodes it and shifts it out 2 bits per cycle.
// A word captured in frame N leaves during frame N+1; an empty request window sends a K28.5 comma instead.
module eproc_out_enc8b10b (
  input  logic       bitCLK,
  input  logic       rst,
  input  logic [9:0] edataIN,
  input  logic       DATA_RDY,
  input  logic       swap_outbits,
  input  logic       fhCR_REVERSE_10B,
  output logic       getDataTrig,
  output logic [1:0] EDATA_OUT,
  output logic [9:0] enc10bit
);

  localparam logic [9:0] COMMA_WORD = 10'h300;

  logic [2:0] send_count, nxt_count;
  logic [9:0] cap_word, enc_word, enc_sym, load_val, sh_reg, sh_next;
  logic       got, rd, rd_mid, rd_end, is_k, use_a7;
  logic [4:0] x5;
  logic [2:0] y3;
  logic [7:0] e6;
  logic [5:0] e4, six;
  logic [3:0] four;
  logic [1:0] pair, out_pair;

  // 5b/6b RD- code {a,b,c,d,e,i}, with {complement-on-RD+, flips-RD} flags on top.
  function automatic logic [7:0] lut6(input logic [4:0] x);
    case (x)
      5'd0:    return 8'b11_100111;
      5'd1:    return 8'b11_011101;
      5'd2:    return 8'b11_101101;
      5'd3:    return 8'b00_110001;
      5'd4:    return 8'b11_110101;
      5'd5:    return 8'b00_101001;
      5'd6:    return 8'b00_011001;
      5'd7:    return 8'b10_111000;
      5'd8:    return 8'b11_111001;
      5'd9:    return 8'b00_100101;
      5'd10:   return 8'b00_010101;
      5'd11:   return 8'b00_110100;
      5'd12:   return 8'b00_001101;
      5'd13:   return 8'b00_101100;
      5'd14:   return 8'b00_011100;
      5'd15:   return 8'b11_010111;
      5'd16:   return 8'b11_011011;
      5'd17:   return 8'b00_100011;
      5'd18:   return 8'b00_010011;
      5'd19:   return 8'b00_110010;
      5'd20:   return 8'b00_001011;
      5'd21:   return 8'b00_101010;
      5'd22:   return 8'b00_011010;
      5'd23:   return 8'b11_111010;
      5'd24:   return 8'b11_110011;
      5'd25:   return 8'b00_100110;
      5'd26:   return 8'b00_010110;
      5'd27:   return 8'b11_110110;
      5'd28:   return 8'b00_001110;
      5'd29:   return 8'b11_101110;
      5'd30:   return 8'b11_011110;
      default: return 8'b11_101011;
    endcase
  endfunction

  // 3b/4b RD- code {f,g,h,j} with the same two flags; y=7 is the primary P7 form.
  function automatic logic [5:0] lut4(input logic [2:0] y);
    case (y)
      3'd0:    return 6'b11_1011;
      3'd1:    return 6'b00_1001;
      3'd2:    return 6'b00_0101;
      3'd3:    return 6'b10_1100;
      3'd4:    return 6'b11_1101;
      3'd5:    return 6'b00_1010;
      3'd6:    return 6'b00_0110;
      default: return 6'b11_1110;
    endcase
  endfunction

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  assign getDataTrig = rst && (send_count == 3'd0);

  always_comb begin
    nxt_count = (send_count == 3'd4) ? 3'd0 : send_count + 3'd1;
    // A word arriving in the last window slot is encoded straight from the input.
    enc_word  = (DATA_RDY && !got) ? edataIN : cap_word;
    is_k      = (enc_word[9:8] != 2'b00);
    x5        = is_k ? 5'd28 : enc_word[4:0];
    case (enc_word[9:8])
      2'b10:   y3 = 3'd1;
      2'b01:   y3 = 3'd6;
      2'b11:   y3 = 3'd5;
      default: y3 = enc_word[7:5];
    endcase
    e6     = is_k ? 8'b11_001111 : lut6(x5);
    six    = (rd && e6[7]) ? ~e6[5:0] : e6[5:0];
    rd_mid = rd ^ e6[6];
    use_a7 = !is_k && (y3 == 3'd7) &&
             (rd_mid ? (x5 == 5'd11 || x5 == 5'd13 || x5 == 5'd14)
                     : (x5 == 5'd17 || x5 == 5'd18 || x5 == 5'd20));
    e4     = use_a7 ? 6'b11_0111 : lut4(y3);
    // K28 uses the inverted neutral fghj so that K28.5 keeps its comma pattern.
    if (is_k) four = rd_mid ? e4[3:0] : ~e4[3:0];
    else      four = (rd_mid && e4[5]) ? ~e4[3:0] : e4[3:0];
    rd_end   = rd_mid ^ e4[4];
    enc_sym  = rev10({six, four});
    load_val = fhCR_REVERSE_10B ? rev10(enc10bit) : enc10bit;
    sh_next  = (send_count == 3'd4) ? load_val : sh_reg;
    case (nxt_count)
      3'd0:    pair = sh_next[1:0];
      3'd1:    pair = sh_next[3:2];
      3'd2:    pair = sh_next[5:4];
      3'd3:    pair = sh_next[7:6];
      default: pair = sh_next[9:8];
    endcase
    out_pair = swap_outbits ? {pair[0], pair[1]} : pair;
  end

  always_ff @(posedge bitCLK or negedge rst) begin
    if (!rst) begin
      send_count <= '0;
      cap_word   <= COMMA_WORD;
      got        <= 1'b0;
      rd         <= 1'b0;
      enc10bit   <= '0;
      sh_reg     <= '0;
      EDATA_OUT  <= '0;
    end else begin
      send_count <= nxt_count;
      sh_reg     <= sh_next;
      EDATA_OUT  <= out_pair;
      case (send_count)
        3'd0: begin
          cap_word <= COMMA_WORD;
          got      <= 1'b0;
        end
        3'd1, 3'd2: begin
          if (DATA_RDY && !got) begin
            cap_word <= edataIN;
            got      <= 1'b1;
          end
        end
        3'd3: begin
          enc10bit <= enc_sym;
          rd       <= rd_end;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eproc_out_enc8b10b.sv
`timescale 1ns/1ps
// Randomised and directed bench for the e-link 8b/10b egress, checked against a table-driven encoder model.
module tb_eproc_out_enc8b10b;

  logic       bitCLK = 1'b0;
  logic       rst;
  logic [9:0] edataIN;
  logic       DATA_RDY;
  logic       swap_outbits;
  logic       fhCR_REVERSE_10B;
  logic       getDataTrig;
  logic [1:0] EDATA_OUT;
  logic [9:0] enc10bit;

  eproc_out_enc8b10b dut (
    .bitCLK           (bitCLK),
    .rst              (rst),
    .edataIN          (edataIN),
    .DATA_RDY         (DATA_RDY),
    .swap_outbits     (swap_outbits),
    .fhCR_REVERSE_10B (fhCR_REVERSE_10B),
    .getDataTrig      (getDataTrig),
    .EDATA_OUT        (EDATA_OUT),
    .enc10bit         (enc10bit)
  );

  always #5 bitCLK = ~bitCLK;

  localparam logic [9:0] IDLE = 10'h300;

  // Standard RD- columns, written abcdei / fghj.
  localparam logic [5:0] D6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [3:0] D4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

  int n_chk = 0;
  int n_fail = 0;

  logic       m_rd;
  logic [9:0] p_sym;
  logic       p_sw, p_rev;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  function automatic logic [9:0] swap_pairs(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 5; i++) begin
      r[2*i]   = v[2*i+1];
      r[2*i+1] = v[2*i];
    end
    return r;
  endfunction

  // Returns {RD after symbol, symbol with a in bit 0}; RD 1 means positive.
  function automatic logic [10:0] enc_fn(input logic [9:0] w, input logic rd_in);
    logic       r;
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] abc;
    logic [4:0] x;
    logic [2:0] y;
    r = rd_in;
    x = w[4:0];
    y = w[7:5];
    case (w[9:8])
      2'b10:   begin abc = r ? 10'b110000_0110 : 10'b001111_1001; r = ~r; end
      2'b01:   begin abc = r ? 10'b110000_1001 : 10'b001111_0110; r = ~r; end
      2'b11:   begin abc = r ? 10'b110000_0101 : 10'b001111_1010; r = ~r; end
      default: begin
        s6 = D6[x];
        if (r && ($countones(s6) != 3 || x == 5'd7)) s6 = ~s6;
        if ($countones(s6) != 3) r = ~r;
        if (y == 3'd7 && ((!r && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                          ( r && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
          s4 = 4'b0111;
        else
          s4 = D4[y];
        if (r && ($countones(s4) != 2 || y == 3'd3)) s4 = ~s4;
        if ($countones(s4) != 2) r = ~r;
        abc = {s6, s4};
      end
    endcase
    return {r, rev10(abc)};
  endfunction

  function automatic logic [8:0] dec_fn(input logic [9:0] s, input logic rd);
    logic [10:0] t;
    for (int c = 0; c < 256; c++) begin
      t = enc_fn({2'b00, 8'(c)}, rd);
      if (t[9:0] == s) return {1'b1, 8'(c)};
    end
    return 9'h0;
  endfunction

  function automatic bit disp_ok(input logic [9:0] s, input logic rd);
    int o6 = $countones(s[5:0]);
    int o4 = $countones(s[9:6]);
    bit r  = rd;
    bit ok = 1'b1;
    if (o6 == 4)      begin ok &= !r; r = 1'b1; end
    else if (o6 == 2) begin ok &= r;  r = 1'b0; end
    else if (o6 != 3) ok = 1'b0;
    if (o4 == 3)      begin ok &= !r; r = 1'b1; end
    else if (o4 == 1) begin ok &= r;  r = 1'b0; end
    else if (o4 != 2) ok = 1'b0;
    return ok;
  endfunction

  task automatic do_reset();
    rst      = 1'b0;
    DATA_RDY = 1'b0;
    edataIN  = '0;
    repeat (3) @(posedge bitCLK);
    #1;
    check("rst_edata", 10'(EDATA_OUT), 10'h000);
    check("rst_trig",  10'(getDataTrig), 10'h000);
    check("rst_enc",   enc10bit, 10'h000);
    #1 rst = 1'b1;
    m_rd  = 1'b0;
    p_sym = '0;
    p_sw  = swap_outbits;
    p_rev = 1'b0;
  endtask

  // One 5-cycle frame: drives per-slot DATA_RDY/edataIN, checks request, serial output and encoding.
  task automatic step(input logic [4:0] rv, input logic [49:0] dv, input logic sw, input logic rev,
                      output logic [9:0] sym, output logic [9:0] outs);
    logic [9:0]  sh, exp_out, cap;
    logic [10:0] m;
    sh      = p_rev ? rev10(p_sym) : p_sym;
    exp_out = p_sw ? swap_pairs(sh) : sh;
    sym     = '0;
    outs    = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge bitCLK);
      outs[2*k +: 2] = EDATA_OUT;
      check("trig", 10'(getDataTrig), 10'(k == 0));
      if (k == 4) sym = enc10bit;
      if (k == 0) begin
        swap_outbits     = sw;
        fhCR_REVERSE_10B = rev;
      end
      DATA_RDY = rv[k];
      edataIN  = dv[10*k +: 10];
    end
    if (sw == p_sw) check("edata", outs, exp_out);
    cap = IDLE;
    for (int k = 3; k >= 1; k--) if (rv[k]) cap = dv[10*k +: 10];
    m = enc_fn(cap, m_rd);
    check("enc", sym, m[9:0]);
    m_rd  = m[10];
    p_sym = m[9:0];
    p_sw  = sw;
    p_rev = rev;
  endtask

  task automatic step1(input logic [9:0] w, input int slot, input logic sw, input logic rev,
                       output logic [9:0] sym, output logic [9:0] outs);
    step(5'(1 << slot), {5{w}}, sw, rev, sym, outs);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  sym, outs;
    logic        rd0, sw, rv_rev;
    logic [8:0]  dr;
    logic [4:0]  rv;
    logic [49:0] dv;
    rst = 1'b0; DATA_RDY = 1'b0; edataIN = '0; swap_outbits = 1'b0; fhCR_REVERSE_10B = 1'b0;
    do_reset();

    step1(IDLE, 5, 1'b0, 1'b0, sym, outs);
    check("idle0", sym, 10'h17C);
    check("first_frame_out", outs, 10'h000);
    step1(IDLE, 5, 1'b0, 1'b0, sym, outs);
    check("idle1", sym, 10'h283);
    step1(10'h000, 1, 1'b0, 1'b0, sym, outs);
    check("d0_0", sym, 10'h0B9);
    step1(IDLE, 5, 1'b0, 1'b0, sym, outs);
    check("rd_after_d0", sym, 10'h17C);

    step1(10'h055, 2, 1'b0, 1'b0, sym, outs);
    check("d21_2", sym, 10'h295);
    step1(10'h055, 3, 1'b0, 1'b0, sym, outs);
    check("ser_plain", outs, 10'h295);
    step1(10'h055, 1, 1'b1, 1'b0, sym, outs);
    step1(10'h055, 1, 1'b1, 1'b0, sym, outs);
    check("ser_swap", outs, 10'h16A);
    step1(10'h055, 1, 1'b0, 1'b1, sym, outs);
    step1(10'h055, 1, 1'b0, 1'b1, sym, outs);
    check("ser_rev", outs, 10'h2A5);

    step1(10'h2A7, 2, 1'b0, 1'b0, sym, outs);
    check("k28_1_rdpos", sym, 10'h183);
    step1(10'h1C3, 3, 1'b0, 1'b0, sym, outs);
    check("k28_6_rdneg", sym, 10'h1BC);

    // Abort a frame at send_count==2 while a D21.2 symbol is on the wire.
    step1(10'h055, 1, 1'b0, 1'b0, sym, outs);
    for (int k = 0; k < 3; k++) begin
      @(negedge bitCLK);
      DATA_RDY = 1'b0;
    end
    check("pre_rst_slot2", 10'(EDATA_OUT), 10'h001);
    rst = 1'b0;
    #1;
    check("mid_rst_edata", 10'(EDATA_OUT), 10'h000);
    check("mid_rst_enc", enc10bit, 10'h000);
    do_reset();
    step1(IDLE, 5, 1'b0, 1'b0, sym, outs);
    check("post_rst_k28", sym, 10'h17C);
    check("post_rst_out", outs, 10'h000);

    for (int b = 0; b < 256; b++) begin
      rd0 = m_rd;
      step1({2'b00, 8'(b)}, 1 + (b % 3), 1'b0, 1'b0, sym, outs);
      dr = dec_fn(sym, rd0);
      check("dec_found", 10'(dr[8]), 10'h001);
      check("dec_byte", {2'b00, dr[7:0]}, {2'b00, 8'(b)});
      check("disparity", 10'(disp_ok(sym, rd0)), 10'h001);
    end

    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 5; k++) dv[10*k +: 10] = 10'($urandom);
      step(5'b11111, dv, 1'b0, 1'b0, sym, outs);
    end

    sw = 1'b0;
    rv_rev = 1'b0;
    for (int f = 0; f < 150; f++) begin
      if (f % 10 == 0) begin
        sw     = 1'($urandom);
        rv_rev = 1'($urandom);
      end
      rv = 5'($urandom);
      for (int k = 0; k < 5; k++) dv[10*k +: 10] = 10'($urandom);
      step(rv, dv, sw, rv_rev, sym, outs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
